// File: rtl/ram16k_arbiter_if.sv
// Bus bundle between the two requesters, the RAM and the arbiter.
// The arbiter sits on the slave modport; the environment around it
// (CPU port, scanout port and the RAM itself) sits on the master modport.
`timescale 1ns/1ps
interface ram16k_arbiter_if;
  // Port A: CPU data, reads and writes
  logic        a_req;
  logic        a_we;
  logic [13:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_gnt;
  logic        a_rvalid;
  logic [15:0] a_rdata;

  // Port B: screen scanout, reads only
  logic        b_req;
  logic [13:0] b_addr;
  logic        b_gnt;
  logic        b_rvalid;
  logic [15:0] b_rdata;

  // RAM side
  logic        ram_load;
  logic [13:0] ram_address;
  logic [15:0] ram_in_value;
  logic [15:0] ram_out;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_addr,
    output b_gnt, b_rvalid, b_rdata,
    output ram_load, ram_address, ram_in_value,
    input  ram_out
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_addr,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_load, ram_address, ram_in_value,
    output ram_out
  );
endinterface

// File: rtl/ram16k_arbiter.sv
// Two-port arbiter and sequencer in front of the 16K x 16 data RAM.
// Port A (CPU) reads and writes, port B (scanout) only reads. One request is
// accepted per cycle into a command stage that drives the RAM directly; read
// responses come back two cycles after acceptance on the originating port.
// When nothing is accepted the RAM is parked in a read so it never writes.
`timescale 1ns/1ps
module ram16k_arbiter #(
  parameter int ARB_MODE = 0,  // 0 = round-robin, 1 = A priority with B escalation
  parameter int MAX_WAIT = 8   // ARB_MODE=1: B wins after this many lost cycles (1..255)
) (
  input  logic              clk,
  input  logic              rst_n,
  ram16k_arbiter_if.slave   bus
);

  localparam int DATA_W = 16;
  localparam int ADDR_W = 14;
  localparam int WAIT_W = 8;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Saturating increment for the B starvation counter.
  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    if (v == {WAIT_W{1'b1}}) begin
      return v;
    end
    return v + {{(WAIT_W-1){1'b0}}, 1'b1};
  endfunction

  // Arbitration state
  port_e              last_win;
  logic [WAIT_W-1:0]  wait_cnt;

  // Arbitration decisions (combinational)
  logic               conflict;
  logic               b_escalate;
  logic               a_gnt_c;
  logic               b_gnt_c;

  // Command stage
  logic               vld_p0;
  port_e              port_p0;
  logic               we_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [DATA_W-1:0]  wdata_p0;

  // Response stage
  logic               vld_p1;
  port_e              port_p1;

  assign conflict   = bus.a_req & bus.b_req;
  assign b_escalate = (int'(wait_cnt) >= MAX_WAIT);

  // Pick at most one requester; nothing is granted while reset is asserted.
  always_comb begin
    a_gnt_c = 1'b0;
    b_gnt_c = 1'b0;
    if (rst_n) begin
      if (conflict) begin
        if (ARB_MODE == 0) begin
          a_gnt_c = (last_win == PORT_B);
        end else begin
          a_gnt_c = ~b_escalate;
        end
        b_gnt_c = ~a_gnt_c;
      end else begin
        a_gnt_c = bus.a_req;
        b_gnt_c = bus.b_req;
      end
    end
  end

  // Remember who won the most recent conflict for round-robin fairness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_win <= PORT_B;
    end else if (conflict) begin
      last_win <= a_gnt_c ? PORT_A : PORT_B;
    end
  end

  // Count consecutive cycles that B waits; cleared when B is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (bus.b_req && b_gnt_c) begin
      wait_cnt <= '0;
    end else if (bus.b_req) begin
      wait_cnt <= sat_inc(wait_cnt);
    end
  end

  // ---- stage p0: command register, accepted request drives the RAM ----
  // Capture the accepted request; address and write data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      we_p0    <= 1'b0;
      port_p0  <= PORT_A;
      addr_p0  <= '0;
      wdata_p0 <= '0;
    end else begin
      vld_p0 <= a_gnt_c | b_gnt_c;
      we_p0  <= a_gnt_c & bus.a_we;
      if (a_gnt_c) begin
        port_p0  <= PORT_A;
        addr_p0  <= bus.a_addr;
        wdata_p0 <= bus.a_wdata;
      end else if (b_gnt_c) begin
        port_p0  <= PORT_B;
        addr_p0  <= bus.b_addr;
      end
    end
  end

  // ---- stage p1: response register, RAM output is valid alongside it ----
  // Only reads produce a response; writes retire silently at the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      port_p1 <= PORT_A;
    end else begin
      vld_p1  <= vld_p0 & ~we_p0;
      port_p1 <= port_p0;
    end
  end

  assign bus.a_gnt        = a_gnt_c;
  assign bus.b_gnt        = b_gnt_c;

  assign bus.ram_load     = ~(vld_p0 & we_p0);
  assign bus.ram_address  = addr_p0;
  assign bus.ram_in_value = wdata_p0;

  assign bus.a_rvalid     = vld_p1 & (port_p1 == PORT_A);
  assign bus.b_rvalid     = vld_p1 & (port_p1 == PORT_B);
  assign bus.a_rdata      = bus.ram_out;
  assign bus.b_rdata      = bus.ram_out;

endmodule

// File: doc/ram16k_arbiter.md
# ram16k_arbiter

Two-port arbiter and sequencer in front of the 16K x 16 data RAM (ram16k). Port A (CPU data) issues reads and writes; port B (screen scanout) issues reads only. The block picks one request per cycle and registers it into a command stage that drives the RAM. It then routes registered read data back to the originating port with a valid strobe. While idle, it parks the RAM in a harmless read so that no spurious write can occur.

## Interface
- ARB_MODE, 0: 0 = round-robin A/B; 1 = fixed priority A, with B escalation.
- MAX_WAIT, 8: ARB_MODE=1 only. Once B has waited this many consecutive cycles, B wins the next arbitration. Legal range 1..255.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request; must hold stable with its fields until accepted.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  14  port A word address.
- a_wdata  in  16  port A write data.
- a_gnt  out  1  combinational; the request is accepted on an edge where a_req & a_gnt.
- a_rvalid  out  1  one-cycle pulse; a_rdata is valid.
- a_rdata  out  16  read data for port A.
- b_req  in  1  port B read request.
- b_addr  in  14  port B word address.
- b_gnt  out  1  combinational accept for port B.
- b_rvalid  out  1  one-cycle pulse; b_rdata is valid.
- b_rdata  out  16  read data for port B.
- ram_load  out  1  RAM control: 1 = read (latch RAM[address] into the RAM output register), 0 = write in_value.
- ram_address  out  14  RAM address.
- ram_in_value  out  16  RAM write data.
- ram_out  in  16  RAM registered read data.

## Operation
- Arbitration is combinational each cycle. At most one of a_gnt and b_gnt is high.
  - A grant is only given to a requesting port.
  - With a single requester, that requester is granted.
- ARB_MODE=0:
  - On conflict, the winner is the port that did not win the last conflict.
  - The last-winner register resets to B, so A wins the first conflict.
- ARB_MODE=1:
  - On conflict, A wins unless wait_cnt >= MAX_WAIT.
  - wait_cnt (8-bit, saturating) increments each cycle that b_req=1 and b_gnt=0.
  - wait_cnt clears on b acceptance.
- Command stage, registered on each accepted request:
  - Captures cmd_valid=1, cmd_port, cmd_we, cmd_addr and cmd_wdata. Port B always sets cmd_we=0.
  - With no acceptance: cmd_valid=0, cmd_we=0; cmd_addr and cmd_wdata hold.
- RAM drive is taken directly from the command stage:
  - ram_load = ~(cmd_valid & cmd_we).
  - ram_address = cmd_addr.
  - ram_in_value = cmd_wdata.
- An idle or read cycle therefore presents ram_load=1. A write cycle is never presented without a valid write command.
- Response stage, registered from the command stage:
  - rsp_valid = cmd_valid & ~cmd_we; rsp_port = cmd_port.
  - a_rvalid = rsp_valid & (rsp_port==A); b_rvalid = rsp_valid & (rsp_port==B).
  - a_rdata = b_rdata = ram_out, which is valid only under the respective rvalid.
- Writes produce no response.
- Ordering: accesses execute in acceptance order. A read of an address issued after a write to it returns the new data.

## Timing
- Accept at edge E0 → RAM access at edge E1. For reads, rvalid is high in the cycle after E1 (sampled at E2).
- Read latency is 2 cycles from acceptance. A write takes effect at E1.
- Throughput is one access per cycle; back-to-back accepts are allowed on either port.
- Reset (rst_n=0, asynchronous):
  - cmd_valid=0, cmd_we=0, cmd_addr=0, cmd_wdata=0, rsp_valid=0.
  - last-winner=B, wait_cnt=0.
  - Outputs: ram_load=1, ram_address=0, ram_in_value=0, a_rvalid=b_rvalid=0.
  - a_gnt and b_gnt are forced to 0 while rst_n=0.
- Reset mid-operation: in-flight commands and responses are discarded with no rvalid. A write not yet at E1 is not performed.
- Reset release: arbitration is live in the first cycle with rst_n=1.
- Requester rule: req and its fields must remain stable until accepted. A dropped req before acceptance is legal and has no effect.
- wait_cnt saturates at 255. It does not change when b_req=0.

## Test plan
- Reset: hold rst_n=0 → ram_load=1, ram_address=0, rvalid both 0, gnt both 0. Release and single A write to 0x0005 data 0xBEEF → ram_load=0 for exactly one cycle (E1), ram_address=0x0005.
- Read-after-write: A writes 0x1234 to 0x3FFF, then reads 0x3FFF on the next cycle → a_rvalid two cycles after read acceptance, a_rdata=0x1234; b_rvalid stays 0.
- Round-robin (ARB_MODE=0): A and B both request continuously (B reading 0x0010.., A reading 0x0020..) → grants alternate A,B,A,B; rvalids return in the same order with correct data.
- Priority/escalation (ARB_MODE=1, MAX_WAIT=3): A and B both request continuously → A granted 3 cycles, B granted on the 4th, then the pattern repeats; wait_cnt never exceeds 3.
- Idle parking: no requests for 20 cycles after preloading RAM[0]=0x0001 → ram_load=1 every cycle, RAM[0] still 0x0001 on a later read.
- Reset mid-read: B read accepted, rst_n pulsed low before b_rvalid → no rvalid; next B read of the same address returns correct data with 2-cycle latency.
